control_cmd_dumpframe: RTL and testbench

- Read-back counterpart of the frame-load command: on `start`, walks the entire framebuffer and streams every byte out to the serial transmitter over a valid/ready handshake.
- Byte order is exactly the order the frame loader consumes, so a dump can be replayed unchanged as a load (round-trip).
- Sits between the framebuffer read port and the control-side UART TX path.

---
 rtl/control_cmd_dumpframe_pkg.sv | 55 +++++
 rtl/control_cmd_dumpframe_fifo.sv | 62 ++++++
 rtl/control_cmd_dumpframe.sv | 125 ++++++++++++
 tb/tb_control_cmd_dumpframe.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/control_cmd_dumpframe_pkg.sv
// Shared framebuffer geometry, address type and address-walk helpers used by
// both the frame-load and frame-dump commands.
package control_cmd_dumpframe_pkg;

    localparam int PIXEL_WIDTH     = 4;
    localparam int PIXEL_HEIGHT    = 3;
    localparam int BYTES_PER_PIXEL = 3;

    localparam int ROW_W = (PIXEL_HEIGHT > 1)    ? $clog2(PIXEL_HEIGHT)    : 1;
    localparam int COL_W = (PIXEL_WIDTH > 1)     ? $clog2(PIXEL_WIDTH)     : 1;
    localparam int PIX_W = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;

    localparam int TOTAL_FB_BYTES = PIXEL_WIDTH * PIXEL_HEIGHT * BYTES_PER_PIXEL;
    localparam int BYTE_CNT_W     = $clog2(TOTAL_FB_BYTES + 1);

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
        logic [PIX_W-1:0] pixel;
    } fb_addr_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } dump_state_t;

    // First address of a frame walk: row 0, col 0, highest byte of the pixel.
    function automatic fb_addr_t fb_addr_first();
        fb_addr_t a;
        a       = '0;
        a.pixel = PIX_W'(BYTES_PER_PIXEL - 1);
        return a;
    endfunction

    // Next address: pixel bytes descend innermost, then columns, then rows.
    function automatic fb_addr_t fb_addr_next(input fb_addr_t a);
        fb_addr_t n;
        n = a;
        if (a.pixel != '0) begin
            n.pixel = a.pixel - PIX_W'(1);
        end else begin
            n.pixel = PIX_W'(BYTES_PER_PIXEL - 1);
            if (a.col != COL_W'(PIXEL_WIDTH - 1)) begin
                n.col = a.col + COL_W'(1);
            end else begin
                n.col = '0;
                n.row = (a.row != ROW_W'(PIXEL_HEIGHT - 1)) ? a.row + ROW_W'(1) : '0;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/control_cmd_dumpframe_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count and flush;
// used as the skid buffer between framebuffer read data and the transmitter.
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr_reg];
    assign count   = count_reg;

    // Pointer and occupancy bookkeeping; flush discards everything held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr_reg] <= push_data;
    end

    // Upstream credit accounting must make a push into a full FIFO impossible.
    always_ff @(posedge clk) begin
        if (reset && !flush) assert (!(push && full && !pop));
    end

endmodule

// File: rtl/control_cmd_dumpframe.sv
// Frame dump command: walks the whole framebuffer in load order and streams
// each byte to the transmitter, issuing reads only against FIFO credit.
module control_cmd_dumpframe
    import control_cmd_dumpframe_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int BUF_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    output fb_addr_t   addr,
    output logic       ram_read_enable,
    input  logic [7:0] ram_data_in,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       done
);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    dump_state_t             state_reg;
    dump_state_t             state_next;
    fb_addr_t                addr_reg;
    logic [BYTE_CNT_W-1:0]   issue_count_reg;
    logic [CNT_W-1:0]        in_flight_reg;
    logic [READ_LATENCY-1:0] valid_pipe_reg;
    logic [READ_LATENCY:0]   valid_pipe_shift;
    logic [CNT_W-1:0]        fifo_count;
    logic                    fifo_empty;
    logic [7:0]              fifo_head;
    logic                    cancel;
    logic                    accept_start;
    logic                    credit_ok;
    logic                    issue;
    logic                    last_issue;
    logic                    push;
    logic                    pop;
    logic                    drain_done;

    assign cancel       = abort && (state_reg != ST_IDLE);
    assign accept_start = (state_reg == ST_IDLE) && start && !abort;
    // Outstanding reads plus buffered bytes must leave room for one more.
    assign credit_ok    = ({1'b0, fifo_count} + {1'b0, in_flight_reg}) < (CNT_W + 1)'(BUF_DEPTH);
    assign issue        = (state_reg == ST_ISSUE) && !abort && credit_ok;
    assign last_issue   = (issue_count_reg == BYTE_CNT_W'(TOTAL_FB_BYTES - 1));
    assign push         = valid_pipe_reg[READ_LATENCY-1];
    assign pop          = tx_valid && tx_ready;
    // Finish in the cycle the last byte leaves so done follows it directly.
    assign drain_done   = (in_flight_reg == '0) &&
                          (fifo_empty || ((fifo_count == CNT_W'(1)) && pop));
    assign valid_pipe_shift = {valid_pipe_reg, issue};

    assign addr            = addr_reg;
    assign ram_read_enable = issue;
    assign tx_valid        = !fifo_empty;
    assign tx_data         = tx_valid ? fifo_head : 8'h00;
    assign busy            = (state_reg == ST_ISSUE) || (state_reg == ST_DRAIN);
    assign done            = (state_reg == ST_DONE);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    // Next-state decode: abort beats everything, including a same-cycle start.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (accept_start) state_next = ST_ISSUE;
            ST_ISSUE: begin
                if (cancel)                   state_next = ST_IDLE;
                else if (issue && last_issue) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (cancel)          state_next = ST_IDLE;
                else if (drain_done) state_next = ST_DONE;
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Address walk, issue count and outstanding-read count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_reg        <= '0;
            issue_count_reg <= '0;
            in_flight_reg   <= '0;
            valid_pipe_reg  <= '0;
        end else if (cancel) begin
            in_flight_reg  <= '0;
            valid_pipe_reg <= '0;
        end else begin
            if (accept_start) begin
                addr_reg        <= fb_addr_first();
                issue_count_reg <= '0;
            end else if (issue) begin
                issue_count_reg <= issue_count_reg + BYTE_CNT_W'(1);
                if (!last_issue) addr_reg <= fb_addr_next(addr_reg);
            end
            in_flight_reg  <= in_flight_reg + CNT_W'(issue) - CNT_W'(push);
            valid_pipe_reg <= valid_pipe_shift[READ_LATENCY-1:0];
        end
    end

    sync_fifo_fwft #(
        .WIDTH (8),
        .DEPTH (BUF_DEPTH)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (cancel),
        .push      (push),
        .push_data (ram_data_in),
        .pop       (pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_control_cmd_dumpframe.sv
// Bench for the frame dump command: three instances (latency/depth variants),
// each with a RAM model returning the byte's position in dump order.
module tb_control_cmd_dumpframe;
    import control_cmd_dumpframe_pkg::*;

    localparam int NI    = 3;
    localparam int RXMAX = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_s    [NI];
    logic       abort_s    [NI];
    fb_addr_t   addr_s     [NI];
    logic       rre_s      [NI];
    logic [7:0] ram_data_s [NI];
    logic [7:0] tx_data_s  [NI];
    logic       tx_valid_s [NI];
    logic       tx_ready_s [NI];
    logic       busy_s     [NI];
    logic       done_s     [NI];

    int         n_assert = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         mode        [NI];
    int         rx_n        [NI];
    int         first_strobe[NI];
    int         first_valid [NI];
    int         last_hs     [NI];
    int         prev_hs     [NI];
    int         gaps        [NI];
    int         done_n      [NI];
    int         done_cyc    [NI];
    int         stall_err   [NI];
    logic       stalled     [NI];
    logic [7:0] held        [NI];
    fb_addr_t   first_addr  [NI];
    logic [7:0] rx_b        [NI][RXMAX];

    always #5 clk = ~clk;

    function automatic int rl_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // Position of an address in the dump stream: rows, then columns, then
    // pixel bytes from the highest down.
    function automatic logic [7:0] lin_byte(input fb_addr_t a);
        int idx;
        idx = (int'(a.row) * PIXEL_WIDTH + int'(a.col)) * BYTES_PER_PIXEL
              + (BYTES_PER_PIXEL - 1 - int'(a.pixel));
        return 8'(idx);
    endfunction

    function automatic logic [NI-1:0] onehot(input int k);
        logic [NI-1:0] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int RL = (gi == 0) ? 1 : 3;
        localparam int BD = (gi == 2) ? 8 : 4;
        logic [7:0] ram_pipe [RL];

        control_cmd_dumpframe #(
            .READ_LATENCY (RL),
            .BUF_DEPTH    (BD)
        ) u_dut (
            .clk             (clk),
            .reset           (reset),
            .start           (start_s[gi]),
            .abort           (abort_s[gi]),
            .addr            (addr_s[gi]),
            .ram_read_enable (rre_s[gi]),
            .ram_data_in     (ram_data_s[gi]),
            .tx_data         (tx_data_s[gi]),
            .tx_valid        (tx_valid_s[gi]),
            .tx_ready        (tx_ready_s[gi]),
            .busy            (busy_s[gi]),
            .done            (done_s[gi])
        );

        always @(posedge clk) begin
            ram_pipe[0] <= rre_s[gi] ? lin_byte(addr_s[gi]) : 8'hEE;
            for (int i = RL - 1; i > 0; i--) ram_pipe[i] <= ram_pipe[i-1];
        end
        assign ram_data_s[gi] = ram_pipe[RL-1];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats(input int k);
        rx_n[k] = 0; first_strobe[k] = -1; first_valid[k] = -1; last_hs[k] = -1;
        prev_hs[k] = -1; gaps[k] = 0; done_n[k] = 0; done_cyc[k] = -1;
        stall_err[k] = 0; stalled[k] = 1'b0; held[k] = 8'h00; first_addr[k] = '0;
    endtask

    function automatic logic [63:0] out_vec(input int k);
        return 64'({busy_s[k], done_s[k], tx_valid_s[k], rre_s[k], tx_data_s[k], addr_s[k]});
    endfunction

    // One clock cycle: drive inputs after the falling edge, then observe.
    task automatic tick(input logic [NI-1:0] st, input logic [NI-1:0] ab);
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            start_s[k] = st[k];
            abort_s[k] = ab[k];
            case (mode[k])
                0:       tx_ready_s[k] = 1'b1;
                1:       tx_ready_s[k] = ($urandom_range(99) < 40);
                default: tx_ready_s[k] = 1'b0;
            endcase
        end
        #1;
        cyc++;
        for (int k = 0; k < NI; k++) begin
            if (rre_s[k] && first_strobe[k] < 0) begin
                first_strobe[k] = cyc;
                first_addr[k]   = addr_s[k];
            end
            if (tx_valid_s[k] && first_valid[k] < 0) first_valid[k] = cyc;
            if (stalled[k] && (!tx_valid_s[k] || tx_data_s[k] !== held[k])) stall_err[k]++;
            stalled[k] = tx_valid_s[k] && !tx_ready_s[k] && !ab[k];
            held[k]    = tx_data_s[k];
            if (tx_valid_s[k] && tx_ready_s[k]) begin
                if (rx_n[k] < RXMAX) rx_b[k][rx_n[k]] = tx_data_s[k];
                rx_n[k]++;
                if (prev_hs[k] >= 0 && cyc - prev_hs[k] > 1) gaps[k]++;
                prev_hs[k] = cyc;
                last_hs[k] = cyc;
            end
            if (done_s[k]) begin
                done_n[k]++;
                done_cyc[k] = cyc;
            end
        end
    endtask

    task automatic check_dump(input int k, input string tag);
        fb_addr_t exp_first;
        exp_first       = '0;
        exp_first.pixel = PIX_W'(BYTES_PER_PIXEL - 1);
        check({tag, " bytes"}, 64'(rx_n[k]), 64'(TOTAL_FB_BYTES));
        for (int i = 0; i < TOTAL_FB_BYTES && i < rx_n[k] && i < RXMAX; i++)
            check($sformatf("%s byte%0d", tag, i), 64'(rx_b[k][i]), 64'(8'(i)));
        check({tag, " done count"}, 64'(done_n[k]), 64'd1);
        check({tag, " done lag"}, 64'(done_cyc[k] - last_hs[k]), 64'd1);
        check({tag, " first latency"}, 64'(first_valid[k] - first_strobe[k]), 64'(rl_of(k) + 1));
        check({tag, " first addr"}, 64'(first_addr[k]), 64'(exp_first));
        check({tag, " stall stable"}, 64'(stall_err[k]), 64'd0);
    endtask

    task automatic run_dump(input int k, input int md, input int restart_at, input string tag);
        int  n;
        bit  restarted;
        clear_stats(k);
        mode[k] = md;
        tick(onehot(k), '0);
        tick('0, '0);
        check({tag, " busy"}, 64'(busy_s[k]), 64'd1);
        n = 0;
        restarted = 0;
        while (done_n[k] == 0 && n < 3000) begin
            if (restart_at >= 0 && !restarted && rx_n[k] >= restart_at) begin
                tick(onehot(k), '0);
                restarted = 1;
            end else begin
                tick('0, '0);
            end
            n++;
        end
        check({tag, " timeout"}, 64'(n < 3000), 64'd1);
        repeat (4) tick('0, '0);
        check_dump(k, tag);
    endtask

    initial begin
        int n;
        reset = 1'b0;
        for (int k = 0; k < NI; k++) begin
            start_s[k] = 1'b0; abort_s[k] = 1'b0; tx_ready_s[k] = 1'b0; mode[k] = 0;
            clear_stats(k);
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) check($sformatf("reset outputs%0d", k), out_vec(k), 64'd0);
        reset = 1'b1;

        // Full dump, ready always high, latency 1: no bubbles after the first.
        run_dump(0, 0, -1, "full rl1");
        check("full rl1 gaps", 64'(gaps[0]), 64'd0);

        // Random back-pressure.
        run_dump(0, 1, -1, "rand rl1");
        run_dump(1, 1, -1, "rand rl3");

        // Latency 3 variants.
        run_dump(1, 0, -1, "full rl3 d4");
        run_dump(2, 0, -1, "full rl3 d8");
        check("full rl3 d8 gaps", 64'(gaps[2]), 64'd0);

        // Second start while busy is ignored.
        run_dump(0, 0, 10, "restart ignored");

        // Abort after 7 bytes while the transmitter stalls.
        clear_stats(0);
        mode[0] = 0;
        tick(onehot(0), '0);
        n = 0;
        while (rx_n[0] < 7 && n < 500) begin
            tick('0, '0);
            n++;
        end
        check("abort reach7", 64'(rx_n[0]), 64'd7);
        mode[0] = 2;
        tick('0, onehot(0));
        tick('0, '0);
        check("abort tx_valid", 64'(tx_valid_s[0]), 64'd0);
        check("abort busy", 64'(busy_s[0]), 64'd0);
        repeat (5) tick('0, '0);
        check("abort no done", 64'(done_n[0]), 64'd0);
        run_dump(0, 0, -1, "after abort");

        // Asynchronous reset in the middle of dumps on every instance.
        for (int k = 0; k < NI; k++) begin
            clear_stats(k);
            mode[k] = 1;
        end
        tick('1, '0);
        repeat (15) tick('0, '0);
        #2 reset = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) check($sformatf("async reset outputs%0d", k), out_vec(k), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        run_dump(0, 1, -1, "post reset rl1");
        run_dump(1, 0, -1, "post reset rl3 d4");
        run_dump(2, 1, -1, "post reset rl3 d8");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
